// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the writeback arbiter and its load-return FIFO.
package wb_arb_pkg;

  localparam int WB_XLEN    = 32;
  localparam int REG_ADDR_W = 5;

  // One queued register-file write: destination and value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [WB_XLEN-1:0]    data;
  } wb_req_t;

  // MEM_PRI: FIFO head wins over the pipe. PIPE_PRI: the pipe gets one priority grant.
  typedef enum logic {
    MEM_PRI  = 1'b0,
    PIPE_PRI = 1'b1
  } arb_state_e;

  // One-hot decode of a register address into a 32-bit register mask.
  function automatic logic [31:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [31:0] v;
    v     = '0;
    v[rd] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Load-return FIFO of wb_req_t. Pointers carry one extra wrap bit so that
// full and empty are distinguishable. Per-entry valid/rd vectors let the
// arbiter do WAW hazard compares and build the pending-register mask.
module wb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               push,
  input  wb_req_t                            push_req,
  input  logic                               pop,
  output logic                               full,
  output logic                               empty,
  output wb_req_t                            head,
  output logic [DEPTH-1:0]                   ent_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]   ent_rd
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t       mem_q [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   count;

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem_q[rd_ptr[AW-1:0]];

  // Pointer update; reset discards all contents by emptying the pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Entry storage; contents need no reset because validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr[AW-1:0]] <= push_req;
  end

  // An entry is occupied when its distance from the read pointer is below the count.
  always_comb begin
    ent_valid = '0;
    ent_rd    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = ({1'b0, AW'(AW'(i) - rd_ptr[AW-1:0])} < count);
      ent_rd[i]    = mem_q[i].rd;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Owns the single register-file write port and shares it between the in-order
// pipeline result and the buffered load/mul-div return stream.
// Optional performance counters are built when WB_ARB_PERF_EN is defined.
// XLEN must match wb_arb_pkg::WB_XLEN, the width stored in the FIFO entries.
//
// Handshakes: pipe_valid/pipe_ready and mem_valid/mem_ready transfer on a cycle
// where both are high; ready never depends on being asked except that
// pipe_ready is only meaningful while pipe_valid is high. A pipe result with
// rd==0 is acknowledged immediately and discarded, a mem result with rd==0 is
// accepted and dropped.
module writeback_arbiter
  import wb_arb_pkg::*;
#(
  parameter int XLEN         = WB_XLEN,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_valid,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]       pipe_data,
  output logic                  pipe_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  output logic                  mem_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic [31:0]           rd_pending,
  output arb_state_e            dbg_state
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_conflict_cnt
`endif
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic                               fifo_full;
  logic                               fifo_empty;
  wb_req_t                            fifo_head;
  logic [DEPTH-1:0]                   ent_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0]   ent_rd;

  logic              mem_push;
  logic              waw_hazard;
  logic              pipe_zero;
  logic              pipe_elig;
  logic              pipe_blocked;
  logic              starve_reach;
  logic              grant_pipe;
  logic              grant_fifo;
  arb_state_e        state_q;
  arb_state_e        state_d;
  logic [CNT_W-1:0]  starve_cnt;

  // Full FIFO refuses pushes even if it pops this cycle.
  assign mem_ready = !fifo_full;
  assign mem_push  = mem_valid && mem_ready && (mem_rd != '0);
  assign dbg_state = state_q;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (mem_push),
    .push_req  ('{rd: mem_rd, data: mem_data}),
    .pop       (grant_fifo),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd)
  );

  // WAW hazard: the pipe must not overtake an older queued or arriving load to the same rd.
  always_comb begin
    waw_hazard = 1'b0;
    if (pipe_rd != '0) begin
      if (mem_push && (mem_rd == pipe_rd)) waw_hazard = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_valid[i] && (ent_rd[i] == pipe_rd)) waw_hazard = 1'b1;
      end
    end
  end

  assign pipe_zero  = pipe_valid && (pipe_rd == '0);
  assign pipe_elig  = pipe_valid && (pipe_rd != '0) && !waw_hazard;
  assign pipe_ready = grant_pipe || pipe_zero;

  // Grant selection and FSM next state.
  always_comb begin
    state_d    = state_q;
    grant_pipe = 1'b0;
    grant_fifo = 1'b0;
    if (state_q == PIPE_PRI && pipe_elig) begin
      grant_pipe = 1'b1;
    end else if (!fifo_empty) begin
      grant_fifo = 1'b1;
    end else if (pipe_elig) begin
      grant_pipe = 1'b1;
    end
    pipe_blocked = pipe_valid && (pipe_rd != '0) && !grant_pipe;
    starve_reach = pipe_blocked && (int'(starve_cnt) >= STARVE_LIMIT - 1);
    case (state_q)
      MEM_PRI:  if (starve_reach) state_d = PIPE_PRI;
      PIPE_PRI: if (grant_pipe || !pipe_valid) state_d = MEM_PRI;
      default:  state_d = MEM_PRI;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MEM_PRI;
    else        state_q <= state_d;
  end

  // Starvation counter: saturating count of blocked pipe cycles, cleared on a pipe grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant_pipe) begin
      starve_cnt <= '0;
    end else if (pipe_blocked && (starve_cnt < CNT_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Registered register-file write port; address/data hold when no write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= grant_pipe || grant_fifo;
      if (grant_pipe) begin
        rf_waddr <= pipe_rd;
        rf_wdata <= pipe_data;
      end else if (grant_fifo) begin
        rf_waddr <= fifo_head.rd;
        rf_wdata <= fifo_head.data;
      end
    end
  end

  // Pending-register mask from occupied FIFO entries; x0 is never pending.
  always_comb begin
    rd_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) rd_pending = rd_pending | rd_onehot(ent_rd[i]);
    end
    rd_pending[0] = 1'b0;
  end

`ifdef WB_ARB_PERF_EN
  // Stall and conflict event counters, free-running and wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt    <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (pipe_valid && !pipe_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (pipe_elig && !fifo_empty)  perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`else
  // Without the counters the arbiter is unchanged; no event state is kept.
`endif

endmodule
